// File: rtl/collatz_range_multi.sv
// Multi-lane Collatz range evaluator: LANES engines fill a RAM_WORDS-deep result RAM
// with iteration counts for start..start+RAM_WORDS-1. Define MAX_TRACK_EN for max tracking.
module collatz_range_multi #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int LANES         = 4,
  parameter int N_WIDTH       = 32,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     go,
  input  logic [N_WIDTH-1:0]       start,
  input  logic [RAM_ADDR_BITS-1:0] n,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic                     busy,
  output logic                     done
`ifdef MAX_TRACK_EN
  ,
  output logic [COUNT_WIDTH-1:0]   max_count,
  output logic [RAM_ADDR_BITS-1:0] max_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int INIT_LANES = (LANES < RAM_WORDS) ? LANES : RAM_WORDS;
  localparam int IDX_W      = RAM_ADDR_BITS + 1;

  localparam logic [IDX_W-1:0]       WORDS_L = IDX_W'(RAM_WORDS);
  localparam logic [IDX_W-1:0]       INIT_L  = IDX_W'(INIT_LANES);
  localparam logic [IDX_W-1:0]       IDX_ONE = IDX_W'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE   = COUNT_WIDTH'(1);
  localparam logic [N_WIDTH-1:0]     V_ONE   = N_WIDTH'(1);
  localparam logic [N_WIDTH+1:0]     T_ONE   = (N_WIDTH+2)'(1);

  state_e                   state_q, state_d;
  logic [N_WIDTH-1:0]       start_q, start_d;
  logic [IDX_W-1:0]         next_idx_q, next_idx_d;
  logic [LANES-1:0]         active_q, active_d;
  logic [N_WIDTH-1:0]       v_q   [LANES];
  logic [N_WIDTH-1:0]       v_d   [LANES];
  logic [COUNT_WIDTH-1:0]   c_q   [LANES];
  logic [COUNT_WIDTH-1:0]   c_d   [LANES];
  logic [RAM_ADDR_BITS-1:0] idx_q [LANES];
  logic [RAM_ADDR_BITS-1:0] idx_d [LANES];
  logic [COUNT_WIDTH-1:0]   count_q;

  logic [N_WIDTH+1:0]       triple [LANES];
  logic [N_WIDTH-1:0]       step_v [LANES];
  logic [COUNT_WIDTH-1:0]   res    [LANES];
  logic [LANES-1:0]         ovf;
  logic [LANES-1:0]         req;
  logic [LANES-1:0]         win_oh;

  logic                     wr_en;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [COUNT_WIDTH-1:0]   wr_data;
  logic                     go_ok;
  logic                     reload_ok;

  logic [COUNT_WIDTH-1:0]   ram [RAM_WORDS];

  // Per-lane datapath: 3v+1 is formed two bits wider so overflow past N_WIDTH is visible.
  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      triple[j] = {2'b00, v_q[j]} + {1'b0, v_q[j], 1'b0} + T_ONE;
      ovf[j]    = v_q[j][0] && (triple[j][N_WIDTH+1:N_WIDTH] != 2'b00);
      req[j]    = active_q[j] && ((v_q[j] == V_ONE) || (v_q[j] == '0) || ovf[j]);
      step_v[j] = v_q[j][0] ? triple[j][N_WIDTH-1:0] : (v_q[j] >> 1);
      if (v_q[j] == '0)  res[j] = '0;
      else if (ovf[j])   res[j] = '1;
      else               res[j] = c_q[j];
    end
  end

  // Fixed-priority write arbiter: lowest-numbered requesting lane owns the RAM port.
  always_comb begin
    win_oh  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (req[j] && !wr_en) begin
        win_oh[j] = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = idx_q[j];
        wr_data   = res[j];
      end
    end
  end

  assign go_ok     = go && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign reload_ok = (next_idx_q < WORDS_L);

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    next_idx_d = next_idx_q;
    active_d   = active_q;
    v_d        = v_q;
    c_d        = c_q;
    idx_d      = idx_q;

    if (go_ok) begin
      start_d    = start;
      next_idx_d = INIT_L;
      state_d    = S_RUN;
      for (int j = 0; j < LANES; j++) begin
        if (j < INIT_LANES) begin
          active_d[j] = 1'b1;
          v_d[j]      = start + N_WIDTH'(j);
          c_d[j]      = C_ONE;
          idx_d[j]    = RAM_ADDR_BITS'(j);
        end else begin
          active_d[j] = 1'b0;
        end
      end
    end else begin
      for (int j = 0; j < LANES; j++) begin
        if (active_q[j] && !req[j]) begin
          v_d[j] = step_v[j];
          if (c_q[j] != '1) c_d[j] = c_q[j] + C_ONE;
        end else if (win_oh[j]) begin
          // Finished lanes that lose arbitration stay frozen until they win.
          if (reload_ok) begin
            v_d[j]   = start_q + N_WIDTH'(next_idx_q);
            c_d[j]   = C_ONE;
            idx_d[j] = next_idx_q[RAM_ADDR_BITS-1:0];
          end else begin
            active_d[j] = 1'b0;
          end
        end
      end
      if (wr_en && reload_ok) next_idx_d = next_idx_q + IDX_ONE;

      case (state_q)
        S_RUN:   if (next_idx_q == WORDS_L) state_d = S_DRAIN;
        S_DRAIN: if (active_q == '0) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      next_idx_q <= '0;
      active_q   <= '0;
      count_q    <= '0;
      for (int j = 0; j < LANES; j++) begin
        v_q[j]   <= '0;
        c_q[j]   <= '0;
        idx_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      next_idx_q <= next_idx_d;
      active_q   <= active_d;
      count_q    <= ram[n];
      v_q        <= v_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
    end
  end

  // NOTE: the result RAM has no reset so it maps onto block RAM; partial results survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done  = (state_q == S_DONE);

`ifdef MAX_TRACK_EN
  logic [COUNT_WIDTH-1:0]   max_count_q;
  logic [RAM_ADDR_BITS-1:0] max_idx_q;

  // Ties go to the smaller index so the result is independent of lane completion order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_count_q <= '0;
      max_idx_q   <= '0;
    end else if (go_ok) begin
      max_count_q <= '0;
      max_idx_q   <= '0;
    end else if (wr_en && ((wr_data > max_count_q) ||
                           ((wr_data == max_count_q) && (wr_addr < max_idx_q)))) begin
      max_count_q <= wr_data;
      max_idx_q   <= wr_addr;
    end
  end

  assign max_count = max_count_q;
  assign max_idx   = max_idx_q;
`endif

endmodule

// File: tb/tb_collatz_range_multi.sv
// Bench for collatz_range_multi: compares RAM contents against an arithmetic Collatz
// model for fixed and random ranges; also checks control flow, lane scaling and MAX_TRACK_EN.
module tb_collatz_range_multi;

  localparam int WORDS  = 256;
  localparam int BUDGET = 60000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0, go1 = 1'b0;
  logic [31:0] start = '0, start1 = '0;
  logic [7:0]  n = '0, n1 = '0;
  logic [15:0] count4, count1;
  logic        busy4, done4, busy1, done1;
`ifdef MAX_TRACK_EN
  logic [15:0] max_count4, max_count1;
  logic [7:0]  max_idx4, max_idx1;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q [WORDS];
  logic [15:0] exp_max_count;
  logic [7:0]  exp_max_idx;

  always #5 clk = ~clk;

  collatz_range_multi #(.LANES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .go(go), .start(start), .n(n),
    .count(count4), .busy(busy4), .done(done4)
`ifdef MAX_TRACK_EN
    , .max_count(max_count4), .max_idx(max_idx4)
`endif
  );

  collatz_range_multi #(.LANES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .go(go1), .start(start1), .n(n1),
    .count(count1), .busy(busy1), .done(done1)
`ifdef MAX_TRACK_EN
    , .max_count(max_count1), .max_idx(max_idx1)
`endif
  );

  // Number of values in the sequence from s down to 1, straight from the definition.
  function automatic logic [15:0] ref_count(input logic [31:0] s);
    longint unsigned v;
    int cnt;
    if (s == 0) return 16'h0000;
    v = 64'(s);
    cnt = 1;
    while (v != 1) begin
      if (v % 2 == 1) begin
        v = 3 * v + 1;
        if (v > 64'h0000_0000_FFFF_FFFF) return 16'hFFFF;
      end else begin
        v = v / 2;
      end
      cnt++;
      if (cnt >= 65535) return 16'hFFFF;
    end
    return 16'(cnt);
  endfunction

  task automatic build_model(input logic [31:0] s);
    exp_max_count = 16'h0000;
    exp_max_idx   = 8'h00;
    for (int k = 0; k < WORDS; k++) begin
      exp_q[k] = ref_count(s + 32'(k));
      if (exp_q[k] > exp_max_count) begin
        exp_max_count = exp_q[k];
        exp_max_idx   = 8'(k);
      end
    end
  endtask

  task automatic pulse_go4(input logic [31:0] s);
    @(negedge clk);
    start = s;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
  endtask

  task automatic wait_done4(output int cycles);
    cycles = 0;
    while (done4 !== 1'b1 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (done4 !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done4, cycles);
    end
  endtask

  task automatic read4(input int k, output logic [15:0] val);
    @(negedge clk);
    n = 8'(k);
    @(negedge clk);
    val = count4;
  endtask

  task automatic check_ram4(input string tag);
    logic [15:0] got;
    for (int k = 0; k < WORDS; k++) begin
      read4(k, got);
      vectors++;
      if (got !== exp_q[k]) begin
        miscompares++;
        $display("FAIL %s ram[%0d]: got %h, required %h", tag, k, got, exp_q[k]);
      end
    end
  endtask

  task automatic check_max4(input string tag);
`ifdef MAX_TRACK_EN
    vectors++;
    if (max_count4 !== exp_max_count || max_idx4 !== exp_max_idx) begin
      miscompares++;
      $display("FAIL %s max: got count=%h idx=%0d, required count=%h idx=%0d",
               tag, max_count4, max_idx4, exp_max_count, exp_max_idx);
    end
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Full run on the 4-lane instance: accept, wait, then compare every entry.
  task automatic run4(input logic [31:0] s, input string tag);
    int cyc;
    build_model(s);
    pulse_go4(s);
    vectors++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_go: busy=%b done=%b, required busy=1 done=0", tag, busy4, done4);
    end
    wait_done4(cyc);
    vectors++;
    if (busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_at_done: got %b, required 0", tag, busy4);
    end
    check_max4(tag);
    check_ram4(tag);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || count4 !== 16'h0000 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || count1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: busy=%b/%b done=%b/%b count=%h/%h, required all 0",
               busy4, busy1, done4, done1, count4, count1);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_one;
    logic [15:0] got;
    int idx [5] = '{0, 1, 2, 26, 255};
    logic [15:0] req [5] = '{16'd1, 16'd2, 16'd8, 16'd112, 16'd9};
    run4(32'd1, "start1");
    for (int i = 0; i < 5; i++) begin
      read4(idx[i], got);
      vectors++;
      if (got !== req[i]) begin
        miscompares++;
        $display("FAIL start1_known n=%0d: got %0d, required %0d", idx[i], got, req[i]);
      end
    end
`ifdef MAX_TRACK_EN
    vectors++;
    if (max_count4 !== 16'd128 || max_idx4 !== 8'd230) begin
      miscompares++;
      $display("FAIL start1_max: got %0d@%0d, required 128@230", max_count4, max_idx4);
    end
`endif
    repeat (5) @(negedge clk);
    vectors++;
    if (done4 !== 1'b1) begin
      miscompares++;
      $display("FAIL done_hold: got %b, required 1", done4);
    end
  endtask

  task automatic test_lane_scaling;
    int cyc4 = -1, cyc1 = -1, t = 0;
    logic [15:0] got;
    build_model(32'd1);
    @(negedge clk);
    start = 32'd1; start1 = 32'd1; go = 1'b1; go1 = 1'b1;
    @(negedge clk);
    go = 1'b0; go1 = 1'b0;
    while ((cyc4 < 0 || cyc1 < 0) && t < BUDGET) begin
      if (cyc4 < 0 && done4 === 1'b1) cyc4 = t;
      if (cyc1 < 0 && done1 === 1'b1) cyc1 = t;
      @(negedge clk);
      t++;
    end
    vectors++;
    if (cyc4 < 0 || cyc1 < 0 || cyc4 >= cyc1) begin
      miscompares++;
      $display("FAIL lane_speed: cycles lanes4=%0d lanes1=%0d, required lanes4 < lanes1", cyc4, cyc1);
    end
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      n1 = 8'(k);
      @(negedge clk);
      got = count1;
      vectors++;
      if (got !== exp_q[k]) begin
        miscompares++;
        $display("FAIL lanes1 ram[%0d]: got %h, required %h", k, got, exp_q[k]);
      end
    end
    check_ram4("lanes4");
  endtask

  task automatic test_edges;
    logic [15:0] got;
    run4(32'd0, "start0");
    read4(0, got);
    vectors++;
    if (got !== 16'h0000) begin
      miscompares++; $display("FAIL start0 n=0: got %h, required 0000", got);
    end
    read4(1, got);
    vectors++;
    if (got !== 16'h0001) begin
      miscompares++; $display("FAIL start0 n=1: got %h, required 0001", got);
    end
    run4(32'hFFFF_FFFF, "wrap");
    read4(0, got);
    vectors++;
    if (got !== 16'hFFFF) begin
      miscompares++; $display("FAIL wrap n=0: got %h, required ffff", got);
    end
    read4(1, got);
    vectors++;
    if (got !== 16'h0000) begin
      miscompares++; $display("FAIL wrap n=1: got %h, required 0000", got);
    end
  endtask

  task automatic test_random;
    run4(32'($urandom_range(1, 100000)), "rand_small");
    run4($urandom(), "rand_full");
  endtask

  task automatic test_go_ignored;
    logic [31:0] s1;
    int cyc;
    s1 = 32'($urandom_range(1000, 50000));
    build_model(s1);
    pulse_go4(s1);
    repeat (30) @(negedge clk);
    vectors++;
    if (busy4 !== 1'b1) begin
      miscompares++; $display("FAIL midgo_busy: got %b, required 1", busy4);
    end
    pulse_go4(s1 + 32'd1000);
    wait_done4(cyc);
    check_max4("midgo");
    check_ram4("midgo");
  endtask

  task automatic test_reset_mid;
    pulse_go4(32'($urandom_range(1, 1000000)));
    repeat (25) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b, required 0 0", busy4, done4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_idle: busy=%b done=%b, required 0 0", busy4, done4);
    end
    run4(32'($urandom_range(1, 1000000)), "after_reset");
  endtask

  initial begin
    test_reset();
    test_start_one();
    test_lane_scaling();
    test_edges();
    test_random();
    test_go_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
